rle_line_tracker: RTL and testbench
===================================

Name: rle_line_tracker

Overview:
Parametrised per-line run-length tracker for the binary (thresholded) pixel stream in the VIP path.
- Finds the two longest runs of a selectable target colour on each line and reports their start column and length.
- Discards runs shorter than MIN_SIZE and counts the qualifying runs.
- Handles runs that end on the last pixel, stalled input, line resync and line numbering within a frame.
- Results feed the rover's per-line object-position logic.

Parameters:
IMAGE_W, 640, pixels per line (2..2^CW-1)
CW, 11, width of column, length and line-index fields
MIN_SIZE, 3, minimum run length counted/reported
TARGET, 1'b1, pixel value whose runs are tracked
CNT_W, 4, width of run_count (saturating)

Ports:
CLK  in  1  clock
reset_n  in  1  synchronous active-low reset
pixel_valid  in  1  pixel_in/sol/sof qualify this cycle
pixel_in  in  1  binary pixel
sol  in  1  start of line, valid with pixel_valid
sof  in  1  start of frame (implies sol), valid with pixel_valid
run1_start  out  CW  start column of longest qualifying run
run1_len  out  CW  length of longest qualifying run (0 = none)
run2_start  out  CW  start column of second-longest run
run2_len  out  CW  length of second-longest run (0 = none)
run_count  out  CNT_W  qualifying runs on line, saturates at 2^CNT_W-1
line_idx  out  CW  index of reported line within frame
line_done  out  1  one-cycle pulse: outputs updated

Behaviour:
Reset (reset_n=0 at CLK edge):
- All outputs go to 0.
- Internal column, run state, working top-2, count and line counter clear.
- A reset mid-line discards the partial line; no line_done for it.

Column counter:
- col counts 0..IMAGE_W-1 and advances only on pixel_valid.
- pixel_valid=0 freezes all state (stall-transparent).

Line resync:
- pixel_valid & (sol|sof) treats the pixel as column 0.
- Working state is discarded and no line_done is issued for the truncated line.
- sof also sets the line counter to 0.

Run tracking, on accepted pixel at column c:
- pixel==TARGET and no run open: open run, cur_start=c, cur_len=1.
- pixel==TARGET and run open: cur_len+1.
- pixel!=TARGET and run open: close the candidate (cur_start, cur_len). The current pixel is not part of it.
- c==IMAGE_W-1 and pixel==TARGET: the candidate includes this pixel (run ending at line end is reported).

Commit of candidate (len L):
- L<MIN_SIZE: dropped.
- Otherwise: run_count working value +1, saturating.
- If L>top1_len: top2<=top1, top1<=cand.
- Else if L>top2_len: top2<=cand.
- Strict compare: on ties the earlier run wins.
- Empty slots are start=0, len=0.

End of line, accepted pixel at column IMAGE_W-1:
- On the next edge, outputs load the working results, including any commit made on this same pixel (computed combinationally; no extra cycle).
- line_done=1 for exactly that cycle; line_idx = current line counter.
- Line counter +1, wrapping at 2^CW.
- Column returns to 0; working state clears.
- Latency: line_done is high in the cycle after the last pixel is accepted.
- Outputs hold until the next line_done or reset.
- A sol on the cycle after the last pixel is legal (back-to-back lines, no bubble).

Arithmetic:
- All lengths and columns are unsigned CW bits; no overflow is possible since IMAGE_W<2^CW.
- The run_count saturation must not wrap.

Test Plan:
All scenarios use IMAGE_W=20, MIN_SIZE=3, TARGET=1.
1. Line 00111110000111000000 after sof -> line_done one cycle after the 20th pixel; run1=(2,5), run2=(11,3), run_count=2, line_idx=0.
2. Line with 1s only at cols 15..19 -> run1=(15,5), run2=(0,0), run_count=1 (end-of-line run reported).
3. Line 11011000000000000000 -> run_count=0, run1_len=0, run2_len=0; the two length-2 runs are filtered.
4. Line 11110011110011110000 -> run1=(0,4), run2=(6,4), run_count=3 (tie keeps earliest); a second line then reports line_idx=1.
5. Scenario 1 with pixel_valid deasserted for 1–3 random cycles between pixels -> identical results; line_done exactly one cycle after the last valid pixel.
6. Three further checks:
   - reset_n low for 1 cycle after 10 pixels, then a full line as in scenario 1 -> outputs 0 during reset, exactly one line_done, line_idx=0, results as scenario 1.
   - sol after 7 pixels, then a full line -> no line_done for the partial line.
   - 16 runs of length 3 with IMAGE_W=64 -> run_count saturates at 15.

Source files
------------

// File: rtl/rle_line_tracker.sv
// rle_line_tracker
// Per-line run-length tracker for a binary pixel stream. On every line it finds
// the two longest runs of TARGET pixels (length >= MIN_SIZE), counts the
// qualifying runs and publishes the results with a one-cycle line_done pulse.
//
// Ports:
//   CLK, reset_n          clock, synchronous active-low reset
//   pixel_valid           qualifies pixel_in / sol / sof; low freezes all state
//   pixel_in              binary pixel
//   sol, sof              start of line / start of frame (sof also restarts line count)
//   run1_start, run1_len  longest qualifying run (len 0 = none)
//   run2_start, run2_len  second-longest qualifying run (len 0 = none)
//   run_count             qualifying runs on the line, saturating
//   line_idx              index of the reported line within the frame
//   line_done             one-cycle pulse when the outputs above are updated
module rle_line_tracker #(
    parameter int unsigned IMAGE_W  = 640,
    parameter int unsigned CW       = 11,
    parameter int unsigned MIN_SIZE = 3,
    parameter logic        TARGET   = 1'b1,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             pixel_valid,
    input  logic             pixel_in,
    input  logic             sol,
    input  logic             sof,
    output logic [CW-1:0]    run1_start,
    output logic [CW-1:0]    run1_len,
    output logic [CW-1:0]    run2_start,
    output logic [CW-1:0]    run2_len,
    output logic [CNT_W-1:0] run_count,
    output logic [CW-1:0]    line_idx,
    output logic             line_done
);

    localparam logic [CW-1:0]    LAST_COL = CW'(IMAGE_W - 1);
    localparam logic [CW-1:0]    MIN_LEN  = CW'(MIN_SIZE);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Working state
    logic [CW-1:0]    col_q, col_d;
    logic             open_q, open_d;
    logic [CW-1:0]    cur_start_q, cur_start_d, cur_len_q, cur_len_d;
    logic [CW-1:0]    top1_start_q, top1_start_d, top1_len_q, top1_len_d;
    logic [CW-1:0]    top2_start_q, top2_start_d, top2_len_q, top2_len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    line_q, line_d;

    // Registered outputs
    logic [CW-1:0]    run1_start_q, run1_start_d, run1_len_q, run1_len_d;
    logic [CW-1:0]    run2_start_q, run2_start_d, run2_len_q, run2_len_d;
    logic [CNT_W-1:0] run_count_q, run_count_d;
    logic [CW-1:0]    line_idx_q, line_idx_d;
    logic             line_done_q, line_done_d;

    // A sol/sof pixel sees a freshly cleared line, as if it were column 0.
    logic             restart;
    logic [CW-1:0]    c, w_cur_start, w_cur_len, w_line;
    logic [CW-1:0]    w_t1s, w_t1l, w_t2s, w_t2l;
    logic [CNT_W-1:0] w_cnt;
    logic             w_open, is_tgt, is_last;

    assign restart     = sol | sof;
    assign c           = restart ? '0 : col_q;
    assign w_open      = restart ? 1'b0 : open_q;
    assign w_cur_start = restart ? '0 : cur_start_q;
    assign w_cur_len   = restart ? '0 : cur_len_q;
    assign w_t1s       = restart ? '0 : top1_start_q;
    assign w_t1l       = restart ? '0 : top1_len_q;
    assign w_t2s       = restart ? '0 : top2_start_q;
    assign w_t2l       = restart ? '0 : top2_len_q;
    assign w_cnt       = restart ? '0 : cnt_q;
    assign w_line      = sof ? '0 : line_q;
    assign is_tgt      = (pixel_in == TARGET);
    assign is_last     = (c == LAST_COL);

    logic [CW-1:0]    ext_start, ext_len, cand_start, cand_len;
    logic             cand_valid;
    logic [CW-1:0]    n_t1s, n_t1l, n_t2s, n_t2l;
    logic [CNT_W-1:0] n_cnt;

    always_comb begin
        ext_start  = w_open ? w_cur_start : c;
        ext_len    = w_open ? (w_cur_len + CW'(1)) : CW'(1);
        // A target pixel only closes a run when it is the last pixel of the line;
        // a non-target pixel closes the open run without being part of it.
        cand_valid = is_tgt ? is_last : w_open;
        cand_start = is_tgt ? ext_start : w_cur_start;
        cand_len   = is_tgt ? ext_len : w_cur_len;

        n_t1s = w_t1s;
        n_t1l = w_t1l;
        n_t2s = w_t2s;
        n_t2l = w_t2l;
        n_cnt = w_cnt;
        if (cand_valid && (cand_len >= MIN_LEN)) begin
            if (n_cnt != CNT_MAX) n_cnt = n_cnt + CNT_W'(1);
            // Strict compares: on equal length the earlier run keeps its slot.
            if (cand_len > w_t1l) begin
                n_t2s = w_t1s;
                n_t2l = w_t1l;
                n_t1s = cand_start;
                n_t1l = cand_len;
            end else if (cand_len > w_t2l) begin
                n_t2s = cand_start;
                n_t2l = cand_len;
            end
        end
    end

    always_comb begin
        col_d        = col_q;
        open_d       = open_q;
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        top1_start_d = top1_start_q;
        top1_len_d   = top1_len_q;
        top2_start_d = top2_start_q;
        top2_len_d   = top2_len_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        run1_start_d = run1_start_q;
        run1_len_d   = run1_len_q;
        run2_start_d = run2_start_q;
        run2_len_d   = run2_len_q;
        run_count_d  = run_count_q;
        line_idx_d   = line_idx_q;
        line_done_d  = 1'b0;

        if (pixel_valid) begin
            if (is_last) begin
                run1_start_d = n_t1s;
                run1_len_d   = n_t1l;
                run2_start_d = n_t2s;
                run2_len_d   = n_t2l;
                run_count_d  = n_cnt;
                line_idx_d   = w_line;
                line_done_d  = 1'b1;
                line_d       = w_line + CW'(1);
                col_d        = '0;
                open_d       = 1'b0;
                cur_start_d  = '0;
                cur_len_d    = '0;
                top1_start_d = '0;
                top1_len_d   = '0;
                top2_start_d = '0;
                top2_len_d   = '0;
                cnt_d        = '0;
            end else begin
                col_d        = c + CW'(1);
                open_d       = is_tgt;
                cur_start_d  = is_tgt ? ext_start : '0;
                cur_len_d    = is_tgt ? ext_len : '0;
                top1_start_d = n_t1s;
                top1_len_d   = n_t1l;
                top2_start_d = n_t2s;
                top2_len_d   = n_t2l;
                cnt_d        = n_cnt;
                line_d       = w_line;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            col_q        <= '0;
            open_q       <= 1'b0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            top1_start_q <= '0;
            top1_len_q   <= '0;
            top2_start_q <= '0;
            top2_len_q   <= '0;
            cnt_q        <= '0;
            line_q       <= '0;
            run1_start_q <= '0;
            run1_len_q   <= '0;
            run2_start_q <= '0;
            run2_len_q   <= '0;
            run_count_q  <= '0;
            line_idx_q   <= '0;
            line_done_q  <= 1'b0;
        end else begin
            col_q        <= col_d;
            open_q       <= open_d;
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            top1_start_q <= top1_start_d;
            top1_len_q   <= top1_len_d;
            top2_start_q <= top2_start_d;
            top2_len_q   <= top2_len_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            run1_start_q <= run1_start_d;
            run1_len_q   <= run1_len_d;
            run2_start_q <= run2_start_d;
            run2_len_q   <= run2_len_d;
            run_count_q  <= run_count_d;
            line_idx_q   <= line_idx_d;
            line_done_q  <= line_done_d;
        end
    end

    assign run1_start = run1_start_q;
    assign run1_len   = run1_len_q;
    assign run2_start = run2_start_q;
    assign run2_len   = run2_len_q;
    assign run_count  = run_count_q;
    assign line_idx   = line_idx_q;
    assign line_done  = line_done_q;

endmodule

// File: tb/tb_rle_line_tracker.sv
// Scoreboard bench for rle_line_tracker: instance A (IMAGE_W=20) and instance B
// (IMAGE_W=64, for run_count saturation). The driver pushes hand-computed
// results plus the expected line_done cycle; monitors pop on every line_done.
module tb_rle_line_tracker;

    typedef struct packed {
        logic [10:0] r1s;
        logic [10:0] r1l;
        logic [10:0] r2s;
        logic [10:0] r2l;
        logic [3:0]  cnt;
        logic [10:0] idx;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pv = 1'b0, pin = 1'b0, psol = 1'b0, psof = 1'b0;
    logic sel = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    res_t exp_a[$], exp_b[$];
    int   cyc_a[$], cyc_b[$];

    logic [10:0] r1s_a, r1l_a, r2s_a, r2l_a, idx_a, r1s_b, r1l_b, r2s_b, r2l_b, idx_b;
    logic [3:0]  cnt_a, cnt_b;
    logic        ld_a, ld_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rle_line_tracker #(
        .IMAGE_W(20), .CW(11), .MIN_SIZE(3), .TARGET(1'b1), .CNT_W(4)
    ) u_dut_a (
        .CLK(clk), .reset_n(rst_n), .pixel_valid(pv & ~sel), .pixel_in(pin),
        .sol(psol), .sof(psof), .run1_start(r1s_a), .run1_len(r1l_a),
        .run2_start(r2s_a), .run2_len(r2l_a), .run_count(cnt_a),
        .line_idx(idx_a), .line_done(ld_a)
    );

    rle_line_tracker #(
        .IMAGE_W(64), .CW(11), .MIN_SIZE(3), .TARGET(1'b1), .CNT_W(4)
    ) u_dut_b (
        .CLK(clk), .reset_n(rst_n), .pixel_valid(pv & sel), .pixel_in(pin),
        .sol(psol), .sof(psof), .run1_start(r1s_b), .run1_len(r1l_b),
        .run2_start(r2s_b), .run2_len(r2l_b), .run_count(cnt_b),
        .line_idx(idx_b), .line_done(ld_b)
    );

    function automatic res_t mk(int a, int b, int c, int d, int n, int i);
        mk = '{r1s: 11'(a), r1l: 11'(b), r2s: 11'(c), r2l: 11'(d), cnt: 4'(n), idx: 11'(i)};
    endfunction

    task automatic check_line(input string name, input res_t got, input res_t e,
                              input int gc, input int ec);
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s results: got r1=(%0d,%0d) r2=(%0d,%0d) cnt=%0d idx=%0d required r1=(%0d,%0d) r2=(%0d,%0d) cnt=%0d idx=%0d",
                     name, got.r1s, got.r1l, got.r2s, got.r2l, got.cnt, got.idx,
                     e.r1s, e.r1l, e.r2s, e.r2l, e.cnt, e.idx);
        end
        tests++;
        if (gc != ec) begin
            fails++;
            $display("FAIL %s timing: line_done at cycle %0d required %0d", name, gc, ec);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        if (rst_n && ld_a) begin
            if (exp_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut_a unexpected line_done: got idx=%0d required no pulse", idx_a);
            end else begin
                check_line("dut_a", {r1s_a, r1l_a, r2s_a, r2l_a, cnt_a, idx_a},
                           exp_a.pop_front(), cyc, cyc_a.pop_front());
            end
        end
        if (rst_n && ld_b) begin
            if (exp_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut_b unexpected line_done: got idx=%0d required no pulse", idx_b);
            end else begin
                check_line("dut_b", {r1s_b, r1l_b, r2s_b, r2l_b, cnt_b, idx_b},
                           exp_b.pop_front(), cyc, cyc_b.pop_front());
            end
        end
    end

    // Drives n pixels of a w-pixel line (col 0 = bit w-1), optionally with stalls,
    // and queues the expected result when the line's last pixel is issued.
    task automatic send_line(input logic [63:0] v, input int w, input int n, input bit s,
                             input bit f, input int maxstall, input bit push, input res_t e);
        for (int col = 0; col < n; col++) begin
            if (maxstall > 0 && col > 0) begin
                repeat ($urandom_range(maxstall, 1)) begin
                    @(negedge clk);
                    pv   = 1'b0;
                    pin  = 1'($urandom_range(1, 0));
                    psol = 1'b0;
                    psof = 1'b0;
                end
            end
            @(negedge clk);
            pv   = 1'b1;
            pin  = v[w-1-col];
            psol = (col == 0) && s;
            psof = (col == 0) && f;
        end
        if (push) begin
            if (sel) begin
                exp_b.push_back(e);
                cyc_b.push_back(cyc + 1);
            end else begin
                exp_a.push_back(e);
                cyc_a.push_back(cyc + 1);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pv   = 1'b0;
            psol = 1'b0;
            psof = 1'b0;
        end
    endtask

    task automatic check_zero(input string name);
        logic [63:0] got;
        got = {r1s_a, r1l_a, r2s_a, r2l_a, cnt_a, idx_a, ld_a};
        tests++;
        if (got !== '0 || ld_b !== 1'b0 || r1l_b !== '0 || cnt_b !== '0) begin
            fails++;
            $display("FAIL %s outputs in reset: got a=%h b_len=%0d b_cnt=%0d required 0",
                     name, got, r1l_b, cnt_b);
        end
    endtask

    logic [63:0] s1, s2, s3, s4, s7, sp, sb;

    initial begin
        s1 = 64'b00111110000111000000;
        s2 = 64'b00000000000000011111;
        s3 = 64'b11011000000000000000;
        s4 = 64'b11110011110011110000;
        s7 = 64'b11101111100111111011;
        sp = 64'b11111110000000000000;
        sb = 64'hEEEE_EEEE_EEEE_EEEE;

        repeat (2) @(negedge clk);
        check_zero("initial_reset");
        rst_n = 1'b1;
        idle(2);

        send_line(s1, 20, 20, 0, 1, 0, 1, mk(2, 5, 11, 3, 2, 0));
        send_line(s2, 20, 20, 0, 0, 0, 1, mk(15, 5, 0, 0, 1, 1));
        send_line(s3, 20, 20, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 2));
        idle(3);
        send_line(s4, 20, 20, 0, 1, 0, 1, mk(0, 4, 6, 4, 3, 0));
        send_line(s1, 20, 20, 0, 0, 0, 1, mk(2, 5, 11, 3, 2, 1));
        idle(2);
        send_line(s1, 20, 20, 0, 1, 3, 1, mk(2, 5, 11, 3, 2, 0));
        send_line(s7, 20, 20, 0, 0, 0, 1, mk(11, 6, 4, 5, 3, 1));
        idle(2);

        // Partial line then reset: no report, line counter and column restart.
        send_line(s1, 20, 10, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        pv    = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("mid_line_reset");
        rst_n = 1'b1;
        send_line(s1, 20, 20, 0, 0, 0, 1, mk(2, 5, 11, 3, 2, 0));

        // Truncated line followed by sol: truncated pixels must leave no trace.
        send_line(sp, 20, 7, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
        send_line(s1, 20, 20, 1, 0, 0, 1, mk(2, 5, 11, 3, 2, 1));
        idle(3);

        // Sixteen length-3 runs on the wide instance: count saturates at 15.
        sel = 1'b1;
        send_line(sb, 64, 64, 0, 1, 0, 1, mk(0, 3, 4, 3, 15, 0));
        idle(5);
        sel = 1'b0;

        tests++;
        if (exp_a.size() != 0) begin
            fails++;
            $display("FAIL dut_a missing line_done: got %0d pending required 0", exp_a.size());
        end
        tests++;
        if (exp_b.size() != 0) begin
            fails++;
            $display("FAIL dut_b missing line_done: got %0d pending required 0", exp_b.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
